// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle between the pipeline datapath and its sequencing controller.
//   Parameter CNT_W must match the CNT_W of the pipeline_ctrl it connects to.
//
//   Hazard inputs : fwd_en, id_src1/2, id_src1_valid, id_two_src,
//                   ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en
//   Branch input  : ex_branch_taken
//   SRAM handshake: mem_req, mem_ready
//   Counter ctrl  : cnt_clr
//   Control out   : pc_freeze, if_id_freeze, if_id_flush, id_ex_flush,
//                   back_freeze, mem_timeout
//   Counters out  : stall_cnt, flush_cnt, wait_cnt
//
//   slave  = controller side, master = datapath / bench side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             fwd_en;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_src1_valid;
    logic             id_two_src;
    logic [3:0]       ex_dest;
    logic             ex_wb_en;
    logic             ex_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;

    logic             pc_freeze;
    logic             if_id_freeze;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             back_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport slave (
        input  fwd_en, id_src1, id_src2, id_src1_valid, id_two_src,
               ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
               ex_branch_taken, mem_req, mem_ready, cnt_clr,
        output pc_freeze, if_id_freeze, if_id_flush, id_ex_flush,
               back_freeze, mem_timeout, stall_cnt, flush_cnt, wait_cnt
    );

    modport master (
        output fwd_en, id_src1, id_src2, id_src1_valid, id_two_src,
               ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
               ex_branch_taken, mem_req, mem_ready, cnt_clr,
        input  pc_freeze, if_id_freeze, if_id_flush, id_ex_flush,
               back_freeze, mem_timeout, stall_cnt, flush_cnt, wait_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Decides each cycle whether the five-stage pipeline advances, holds or
//   takes a bubble. Priority: SRAM wait freeze > EX branch redirect > ID data
//   hazard. Tracks long SRAM waits and traps into ERROR after MEM_TIMEOUT
//   cycles. Keeps saturating stall / flush / wait counters.
//
//   Ports:
//     clk  - pipeline clock
//     rst  - synchronous active-high reset
//     bus  - pipeline_ctrl_if.slave (hazard, branch, SRAM and counter I/O)
//
//   Control outputs are combinational from state and inputs and are forced
//   low while rst is high.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);
    localparam int TMO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic mem_freeze;
    logic data_hazard;
    logic branch_apply;
    logic stall_apply;
    logic pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, back_freeze;
    logic mem_timeout;

    // Hazard on one source register. With forwarding only a load in EX
    // cannot be bypassed; without it any pending writer in EX or MEM blocks.
    function automatic logic src_hazard(
        input logic       used,
        input logic [3:0] s,
        input logic       fwd,
        input logic [3:0] exd,
        input logic       ex_wb,
        input logic       ex_rd,
        input logic [3:0] memd,
        input logic       mem_wb
    );
        if (!used)
            return 1'b0;
        if (fwd)
            return ex_rd && ex_wb && (exd == s);
        return (ex_wb && (exd == s)) || (mem_wb && (memd == s));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        tmo_d        = tmo_q;
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        back_freeze  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end
            end
            WAIT: begin
                // A ready in the last allowed cycle still completes the access.
                if (bus.mem_ready)
                    state_d = IDLE;
                else if (tmo_q == TMO_MAX)
                    state_d = ERROR;
                else
                    tmo_d = tmo_q + 1'b1;
            end
            ERROR: ;
            default: state_d = IDLE;
        endcase

        // Mealy freeze: a request answered in the same cycle never stalls.
        mem_freeze = ((state_q == IDLE) && bus.mem_req && !bus.mem_ready) ||
                     ((state_q == WAIT) && !bus.mem_ready) ||
                     (state_q == ERROR);

        data_hazard =
            src_hazard(bus.id_src1_valid, bus.id_src1, bus.fwd_en, bus.ex_dest,
                       bus.ex_wb_en, bus.ex_mem_r_en, bus.mem_dest, bus.mem_wb_en) ||
            src_hazard(bus.id_two_src, bus.id_src2, bus.fwd_en, bus.ex_dest,
                       bus.ex_wb_en, bus.ex_mem_r_en, bus.mem_dest, bus.mem_wb_en);

        // A branch seen while frozen stays in EX and is applied once released.
        branch_apply = !rst && !mem_freeze && bus.ex_branch_taken;
        stall_apply  = !rst && !mem_freeze && !bus.ex_branch_taken && data_hazard;

        if (!rst) begin
            if (mem_freeze) begin
                pc_freeze    = 1'b1;
                if_id_freeze = 1'b1;
                back_freeze  = 1'b1;
            end else if (bus.ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
            end else if (data_hazard) begin
                pc_freeze    = 1'b1;
                if_id_freeze = 1'b1;
                id_ex_flush  = 1'b1;
            end
        end

        mem_timeout = !rst && (state_q == ERROR);

        if (bus.cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
            wait_d  = '0;
        end else begin
            stall_d = sat_inc(stall_q, stall_apply);
            flush_d = sat_inc(flush_q, branch_apply);
            wait_d  = sat_inc(wait_q, !rst && mem_freeze);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.pc_freeze    = pc_freeze;
    assign bus.if_id_freeze = if_id_freeze;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.back_freeze  = back_freeze;
    assign bus.mem_timeout  = mem_timeout;
    assign bus.stall_cnt    = stall_q;
    assign bus.flush_cnt    = flush_q;
    assign bus.wait_cnt     = wait_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl with CNT_W=4 (so saturation is
//   reachable) and MEM_TIMEOUT=4. Inputs change 1 time unit after each rising
//   edge; combinational outputs are sampled 1 unit later, counters right
//   after the edge that updates them.
//   Control vector order: {pc_freeze, if_id_freeze, if_id_flush,
//                          id_ex_flush, back_freeze}.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush,
                    bus.id_ex_flush, bus.back_freeze}, {27'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f, input int w);
        check({tag, "_stall"}, 32'(bus.stall_cnt), s);
        check({tag, "_flush"}, 32'(bus.flush_cnt), f);
        check({tag, "_wait"},  32'(bus.wait_cnt),  w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.fwd_en          = 1'b0;
        bus.id_src1         = 4'd0;
        bus.id_src2         = 4'd0;
        bus.id_src1_valid   = 1'b0;
        bus.id_two_src      = 1'b0;
        bus.ex_dest         = 4'd0;
        bus.ex_wb_en        = 1'b0;
        bus.ex_mem_r_en     = 1'b0;
        bus.mem_dest        = 4'd0;
        bus.mem_wb_en       = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
        bus.cnt_clr         = 1'b0;
    endtask

    // ID reads R3 through src1 while EX writes R3.
    task automatic set_ex_hazard();
        bus.id_src1_valid = 1'b1;
        bus.id_src1       = 4'd3;
        bus.ex_wb_en      = 1'b1;
        bus.ex_dest       = 4'd3;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        set_ex_hazard();
        bus.mem_req = 1'b1;
        #1;
        chk_ctrl("rst_ctrl", 5'b00000);
        check("rst_tmo", 32'(bus.mem_timeout), 0);
        step();
        rst = 1'b0;
        clear_in();
        #1;
        chk_ctrl("post_rst_ctrl", 5'b00000);
        chk_cnt("post_rst", 0, 0, 0);

        // Hazards without forwarding: EX writer, MEM writer via src2, R0.
        set_ex_hazard();
        #1 chk_ctrl("nofwd_ex", 5'b11010);
        step();
        check("nofwd_ex_cnt", 32'(bus.stall_cnt), 1);
        clear_in();
        bus.id_two_src = 1'b1; bus.id_src2 = 4'd7;
        bus.mem_wb_en  = 1'b1; bus.mem_dest = 4'd7;
        #1 chk_ctrl("nofwd_mem_src2", 5'b11010);
        step();
        clear_in();
        bus.id_src1_valid = 1'b1; bus.ex_wb_en = 1'b1;   // R0 vs R0
        #1 chk_ctrl("r0_hazard", 5'b11010);
        step();
        check("r0_cnt", 32'(bus.stall_cnt), 3);
        clear_in();
        set_ex_hazard();
        bus.id_src1_valid = 1'b0;
        #1 chk_ctrl("src_unused", 5'b00000);
        step();

        // Forwarding: only a load in EX stalls, and for one cycle.
        clear_in();
        set_ex_hazard();
        bus.fwd_en = 1'b1; bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd3;
        #1 chk_ctrl("fwd_no_load", 5'b00000);
        step();
        bus.ex_mem_r_en = 1'b1;
        #1 chk_ctrl("fwd_load_use", 5'b11010);
        step();
        bus.ex_mem_r_en = 1'b0; bus.ex_wb_en = 1'b0;     // load moved to MEM
        #1 chk_ctrl("fwd_load_moved", 5'b00000);
        step();
        check("fwd_cnt", 32'(bus.stall_cnt), 4);
        clear_in();

        // Three-cycle SRAM wait.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctrl($sformatf("wait3_c%0d", i), 5'b11001);
            step();
        end
        bus.mem_ready = 1'b1;
        #1 chk_ctrl("wait3_release", 5'b00000);
        step();
        check("wait3_cnt", 32'(bus.wait_cnt), 3);
        clear_in();
        #1 chk_ctrl("wait3_idle", 5'b00000);
        bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
        #1 chk_ctrl("single_cycle_access", 5'b00000);
        step();
        clear_in();
        #1 chk_ctrl("single_cycle_idle", 5'b00000);

        // Branch beats a data hazard.
        set_ex_hazard();
        bus.ex_branch_taken = 1'b1;
        #1 chk_ctrl("branch_hazard", 5'b00110);
        step();
        chk_cnt("branch_hazard", 4, 1, 3);
        clear_in();

        // Branch held through a two-cycle wait, applied on release.
        set_ex_hazard();
        bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1;
        #1 chk_ctrl("branch_wait_c0", 5'b11001);
        step();
        #1 chk_ctrl("branch_wait_c1", 5'b11001);
        step();
        bus.mem_ready = 1'b1;
        #1 chk_ctrl("branch_wait_release", 5'b00110);
        step();
        chk_cnt("branch_wait", 4, 2, 5);
        clear_in();

        // Clear wins over a simultaneous increment.
        set_ex_hazard();
        bus.cnt_clr = 1'b1;
        #1 chk_ctrl("clr_hazard", 5'b11010);
        step();
        chk_cnt("clr", 0, 0, 0);
        clear_in();

        // Saturation of a 4-bit counter.
        set_ex_hazard();
        for (int i = 0; i < 17; i++) step();
        check("stall_saturate", 32'(bus.stall_cnt), 15);
        clear_in();
        bus.cnt_clr = 1'b1;
        step();
        clear_in();

        // Ready in the tmo==MEM_TIMEOUT cycle still completes.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.mem_ready = 1'b1;
        #1 chk_ctrl("tmo_edge_release", 5'b00000);
        check("tmo_edge_flag", 32'(bus.mem_timeout), 0);
        step();
        clear_in();
        #1 chk_ctrl("tmo_edge_idle", 5'b00000);
        check("tmo_edge_wait_cnt", 32'(bus.wait_cnt), 5);

        // Timeout: IDLE request cycle plus five WAIT cycles, then ERROR.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check($sformatf("pre_err_c%0d", i), 32'(bus.mem_timeout), 0);
            step();
        end
        check("err_flag", 32'(bus.mem_timeout), 1);
        chk_ctrl("err_ctrl", 5'b11001);
        bus.mem_ready = 1'b1; bus.mem_req = 1'b0;
        #1 chk_ctrl("err_sticky", 5'b11001);
        step();
        check("err_flag_hold", 32'(bus.mem_timeout), 1);

        // Reset out of ERROR.
        rst = 1'b1;
        #1 chk_ctrl("err_rst_ctrl", 5'b00000);
        check("err_rst_flag", 32'(bus.mem_timeout), 0);
        step();
        rst = 1'b0;
        clear_in();
        #1 chk_ctrl("after_err_ctrl", 5'b00000);
        check("after_err_flag", 32'(bus.mem_timeout), 0);
        chk_cnt("after_err", 0, 0, 0);
        set_ex_hazard();
        #1 chk_ctrl("after_err_hazard", 5'b11010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequences the five-stage ARM pipeline. It decides, every cycle, whether the pipeline registers advance, hold or take a bubble, covering three cases: data hazards between ID and EX/MEM, branch redirect from EX, and multi-cycle SRAM accesses from MEM. It drives the `Flush` input of the ID/EX stage register, the freeze inputs of PC and IF/ID, and the global freeze of the back end. It also keeps saturating performance counters.

## Interface
- `CNT_W`, 16, width of each performance counter
- `MEM_TIMEOUT`, 255, maximum number of cycles in `WAIT` before the controller enters `ERROR`
- `clk`  in  1  pipeline clock
- `rst`  in  1  reset; synchronous to `clk`, active-high
- `fwd_en`  in  1  forwarding unit enabled
- `id_src1`, `id_src2`  in  4 each  register sources of the instruction in ID
- `id_src1_valid`, `id_two_src`  in  1 each  ID reads `id_src1` / also reads `id_src2`
- `ex_dest`  in  4  EX-stage destination register
- `ex_wb_en`, `ex_mem_r_en`  in  1 each  EX-stage control bits
- `mem_dest`  in  4  MEM-stage destination register
- `mem_wb_en`  in  1  MEM-stage control bit
- `ex_branch_taken`  in  1  branch resolved taken in EX
- `mem_req`  in  1  MEM stage has a load or store
- `mem_ready`  in  1  SRAM controller completes the access this cycle
- `cnt_clr`  in  1  synchronous clear of the counters
- `pc_freeze`, `if_id_freeze`  out  1 each  hold PC / hold IF/ID
- `if_id_flush`  out  1  load a bubble into IF/ID
- `id_ex_flush`  out  1  load a bubble into ID/EX (drives its `Flush`)
- `back_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB
- `mem_timeout`  out  1  high while the controller is in `ERROR`
- `stall_cnt`, `flush_cnt`, `wait_cnt`  out  `CNT_W` each  performance counters

## Operation
- FSM states: `IDLE`, `WAIT`, `ERROR`.
  - `IDLE` → `WAIT` when `mem_req && !mem_ready`.
  - `WAIT` → `IDLE` when `mem_ready`.
  - `WAIT` → `ERROR` when the cycle counter `tmo` equals `MEM_TIMEOUT` and `!mem_ready`.
  - `ERROR` is left only by `rst`.
  - `tmo` clears on entry to `WAIT` and increments once per cycle spent in `WAIT`.
- `mem_freeze` = (`IDLE` && `mem_req` && `!mem_ready`) || (`WAIT` && `!mem_ready`) || `ERROR`. This is a Mealy output, so a single-cycle access never freezes.
- `data_hazard` is computed per used source s. A source is used when `id_src1_valid` (s = `id_src1`) or `id_two_src` (s = `id_src2`).
  - With `fwd_en=0`: hazard when (`ex_wb_en` && `ex_dest`==s) || (`mem_wb_en` && `mem_dest`==s).
  - With `fwd_en=1`: hazard only when `ex_mem_r_en` && `ex_wb_en` && `ex_dest`==s (load-use).
- Priority: `mem_freeze` > branch > `data_hazard`.
  - `mem_freeze`: `back_freeze`=`pc_freeze`=`if_id_freeze`=1. All flushes are 0. A pending branch stays held in EX and is applied on the first unfrozen cycle.
  - Branch (`ex_branch_taken`): `if_id_flush`=`id_ex_flush`=1 and no freeze. `data_hazard` is ignored because the ID instruction is squashed.
  - `data_hazard`: `pc_freeze`=`if_id_freeze`=`id_ex_flush`=1 (one bubble per cycle of hazard).
- Counters saturate at all-ones:
  - `stall_cnt` +1 on each data-hazard stall cycle.
  - `flush_cnt` +1 on each applied branch flush.
  - `wait_cnt` +1 on each `mem_freeze` cycle.
  - `cnt_clr` wins over a simultaneous increment.

## Timing
- All state updates on rising `clk`. Outputs are combinational from state and inputs.
- While `rst`=1: every control output is forced to 0. On the next edge the state becomes `IDLE`, `tmo`, all counters and `mem_timeout` become 0.
- Reset mid-`WAIT` or in `ERROR`: the next state is `IDLE` with no freeze.
- Data-hazard latency is 0 cycles: the stall is asserted in the same cycle as the conflict.
- With forwarding, a load-use hazard costs exactly one bubble: the load moves to MEM and the condition clears.
- `mem_ready` and `mem_req` in the same `IDLE` cycle: no freeze and the state stays `IDLE`.
- `mem_ready` arriving in the `tmo==MEM_TIMEOUT` cycle: the access completes and the state returns to `IDLE`.
- Register R0 is a valid hazard source; there is no special casing.

## Test plan
- `fwd_en=0`, ID reads R3, `ex_wb_en=1`, `ex_dest=3` → `pc_freeze`=`if_id_freeze`=`id_ex_flush`=1 for that cycle; `stall_cnt` becomes 1.
- `fwd_en=1`, same stimulus with `ex_mem_r_en=0` → no stall. With `ex_mem_r_en=1` → exactly one stall cycle.
- `mem_req=1`, `mem_ready` low for 3 cycles then high → `back_freeze` high for 3 cycles, low in the 4th; `wait_cnt`=3; state returns to `IDLE`.
- `ex_branch_taken=1` together with a data hazard → `if_id_flush`=`id_ex_flush`=1, no freeze; `flush_cnt`+1, `stall_cnt` unchanged.
- `ex_branch_taken=1` during a 2-cycle memory wait → no flush while frozen; flush asserted in the release cycle.
- `MEM_TIMEOUT=4`, `mem_ready` held low → `ERROR` after 5 `WAIT` cycles with `mem_timeout`=1 and freeze held; `rst` pulse → `IDLE`, all counters 0.
